// File: rtl/sccb_write_master.sv
// sccb_write_master
// -----------------------------------------------------------------------------
// Three-phase SCCB (OV7670 style, I2C compatible) write master. A single write
// sends START, the ID byte, the sub-address byte, the data byte and STOP. Each
// byte is followed by a ninth "don't care" bit during which SIOD is released.
// The bus timing comes from a quarter-bit tick counter running on the system
// clock. SIOC is a registered output and is never used as a clock.
//
// Parameters:
//   QUARTER_CYCLES  system clocks per quarter SIOC period (>= 2)
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     write request, taken only while ready_o = 1
//   dev_addr_i  SCCB ID byte including the write bit, latched on accept
//   reg_addr_i  sub-address byte, latched on accept
//   data_i      data byte, latched on accept
//   ready_o     idle and able to accept start_i
//   done_o      one-cycle pulse when a write completes
//   sioc_o      SIOC level
//   siod_o      SIOD value while driven
//   siod_oe_o   1 = drive SIOD, 0 = release to the pull-up
// -----------------------------------------------------------------------------
module sccb_write_master #(
  parameter int QUARTER_CYCLES = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       sioc_o,
  output logic       siod_o,
  output logic       siod_oe_o
);

  localparam int TW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(QUARTER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BYTE  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [TW-1:0] tick;
  logic [1:0]    quarter;
  logic [1:0]    nxt_quarter;
  logic [3:0]    bit_idx;
  logic [3:0]    nxt_bit;
  logic [1:0]    byte_idx;
  logic [1:0]    nxt_byte;
  logic [7:0]    dev_byte;
  logic [7:0]    reg_byte;
  logic [7:0]    data_byte;
  logic [7:0]    cur_byte;
  logic          quarter_end;
  logic          nxt_sioc;
  logic          nxt_siod;
  logic          nxt_oe;

  assign quarter_end = (tick == TICK_LAST);

  // Bus position after the current cycle. The position only moves when the
  // tick counter wraps, so a quarter always lasts exactly QUARTER_CYCLES.
  // Bits 0..7 carry data MSB first and bit 8 is the released ACK slot.
  always_comb begin
    nxt_state   = state;
    nxt_quarter = quarter;
    nxt_bit     = bit_idx;
    nxt_byte    = byte_idx;
    if (state != IDLE && quarter_end) begin
      if (quarter != 2'd3) begin
        nxt_quarter = quarter + 2'd1;
      end else begin
        nxt_quarter = 2'd0;
        case (state)
          START: begin
            nxt_state = BYTE;
            nxt_bit   = 4'd0;
            nxt_byte  = 2'd0;
          end
          BYTE: begin
            if (bit_idx != 4'd8) begin
              nxt_bit = bit_idx + 4'd1;
            end else if (byte_idx != 2'd2) begin
              nxt_bit  = 4'd0;
              nxt_byte = byte_idx + 2'd1;
            end else begin
              nxt_state = STOP;
            end
          end
          STOP:    nxt_state = IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  // Pin levels for the upcoming bus position. They are computed from the
  // next position and registered, so every pin changes on the same edge
  // that enters a new quarter and no input reaches a pin combinationally.
  // START q2 and STOP q3 are the only places SIOD moves while SIOC is high.
  always_comb begin
    nxt_sioc = 1'b1;
    nxt_siod = 1'b1;
    nxt_oe   = 1'b0;
    case (nxt_byte)
      2'd0:    cur_byte = dev_byte;
      2'd1:    cur_byte = reg_byte;
      default: cur_byte = data_byte;
    endcase
    case (nxt_state)
      START: begin
        nxt_oe   = 1'b1;
        nxt_siod = ~nxt_quarter[1];
      end
      BYTE: begin
        nxt_sioc = nxt_quarter[1];
        if (nxt_bit != 4'd8) begin
          nxt_oe   = 1'b1;
          nxt_siod = cur_byte[~nxt_bit[2:0]];
        end
      end
      STOP: begin
        nxt_oe   = 1'b1;
        nxt_sioc = nxt_quarter[1];
        nxt_siod = (nxt_quarter == 2'd3);
      end
      default: begin
        nxt_sioc = 1'b1;
        nxt_siod = 1'b1;
        nxt_oe   = 1'b0;
      end
    endcase
  end

  // Main FSM with registered outputs. Accepting a request drives the
  // START q0 levels directly, so the first quarter begins on the cycle
  // after the accept. The done cycle is an IDLE cycle, which lets a new
  // request be accepted in it with no idle gap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      tick      <= '0;
      quarter   <= 2'd0;
      bit_idx   <= 4'd0;
      byte_idx  <= 2'd0;
      dev_byte  <= 8'd0;
      reg_byte  <= 8'd0;
      data_byte <= 8'd0;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      sioc_o    <= 1'b1;
      siod_o    <= 1'b1;
      siod_oe_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i && ready_o) begin
          dev_byte  <= dev_addr_i;
          reg_byte  <= reg_addr_i;
          data_byte <= data_i;
          tick      <= '0;
          quarter   <= 2'd0;
          bit_idx   <= 4'd0;
          byte_idx  <= 2'd0;
          state     <= START;
          ready_o   <= 1'b0;
          sioc_o    <= 1'b1;
          siod_o    <= 1'b1;
          siod_oe_o <= 1'b1;
        end
      end else begin
        tick      <= quarter_end ? '0 : tick + 1'b1;
        state     <= nxt_state;
        quarter   <= nxt_quarter;
        bit_idx   <= nxt_bit;
        byte_idx  <= nxt_byte;
        sioc_o    <= nxt_sioc;
        siod_o    <= nxt_siod;
        siod_oe_o <= nxt_oe;
        if (state == STOP && quarter == 2'd3 && quarter_end) begin
          ready_o <= 1'b1;
          done_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master
// -----------------------------------------------------------------------------
// Self-checking bench for sccb_write_master. A fast instance (QUARTER_CYCLES=4)
// is compared every cycle against a position-arithmetic model of the bus. A
// bus decoder also recovers the bytes from the open-drain line. A second
// instance at the default QUARTER_CYCLES=250 has its SIOC timing and done
// latency measured directly.
// -----------------------------------------------------------------------------
module tb_sccb_write_master;

  localparam int Q    = 4;
  localparam int BUSY = 116 * Q;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dev = 8'h00;
  logic [7:0] regb = 8'h00;
  logic [7:0] dat = 8'h00;
  logic       ready, done, sioc, siod, oe;

  logic       start_b = 1'b0;
  logic [7:0] dev_b = 8'h42;
  logic [7:0] reg_b = 8'h12;
  logic [7:0] dat_b = 8'h80;
  logic       ready_b, done_b, sioc_b, siod_b, oe_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sccb_write_master #(.QUARTER_CYCLES(Q)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .dev_addr_i(dev), .reg_addr_i(regb), .data_i(dat),
    .ready_o(ready), .done_o(done), .sioc_o(sioc), .siod_o(siod), .siod_oe_o(oe)
  );

  sccb_write_master dut_slow (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .dev_addr_i(dev_b), .reg_addr_i(reg_b), .data_i(dat_b),
    .ready_o(ready_b), .done_o(done_b), .sioc_o(sioc_b), .siod_o(siod_b), .siod_oe_o(oe_b)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pins from the write's cycle offset kk (1 = first busy cycle).
  // Returned bits: {siod_care, ready, done, sioc, siod, oe}.
  function automatic logic [5:0] expect_out(input int kk, input int qc,
                                            input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    int n, q, m, bi, bt;
    logic [7:0] bb;
    logic s, d, o, c;
    if (kk == 0) return 6'b110110;
    if (kk == 116 * qc + 1) return 6'b111110;
    n = (kk - 1) / qc;
    q = n % 4;
    c = 1'b1;
    o = 1'b1;
    if (n < 4) begin
      s = 1'b1;
      d = (q < 2);
    end else if (n < 112) begin
      m  = (n - 4) / 4;
      bt = m / 9;
      bi = m % 9;
      bb = (bt == 0) ? b0 : (bt == 1) ? b1 : b2;
      s  = (q >= 2);
      if (bi == 8) begin
        o = 1'b0;
        c = 1'b0;
        d = 1'b1;
      end else begin
        d = bb[7 - bi];
      end
    end else begin
      q = n - 112;
      s = (q >= 2);
      d = (q == 3);
    end
    return {c, 1'b0, 1'b0, s, d, o};
  endfunction

  // Reference model: k is the offset into the current write, 0 when idle.
  int         k = 0;
  int         n_accepts = 0;
  int         cyc = 0;
  logic [7:0] mb [3];
  logic [7:0] exp_q [$];
  logic [5:0] e_now;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
    end else if ((k == 0 || k == BUSY + 1) && start) begin
      k     <= 1;
      mb[0] <= dev;
      mb[1] <= regb;
      mb[2] <= dat;
      exp_q.push_back(dev);
      exp_q.push_back(regb);
      exp_q.push_back(dat);
      n_accepts <= n_accepts + 1;
    end else if (k != 0) begin
      k <= (k == BUSY + 1) ? 0 : k + 1;
    end
  end

  assign e_now = expect_out(k, Q, mb[0], mb[1], mb[2]);

  // Per-cycle comparison of the fast instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      check_output("ready", ready, e_now[4]);
      check_output("done", done, e_now[3]);
      check_output("sioc", sioc, e_now[2]);
      check_output("siod_oe", oe, e_now[0]);
      if (e_now[5]) check_output("siod", siod, e_now[1]);
    end
  end

  // Bus decoder on the open-drain line of the fast instance.
  int         nbits = 0;
  int         last_stop = 0;
  int         last_gap = 0;
  logic       psioc = 1'b1;
  logic       psda = 1'b1;
  logic       sda;
  logic [7:0] cur = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      sda = oe ? siod : 1'b1;
      if (!rst_n) begin
        nbits = 0;
        exp_q.delete();
        psioc = 1'b1;
        psda  = 1'b1;
      end else begin
        if (psioc && sioc && psda && !sda) begin
          nbits    = 0;
          last_gap = cyc - last_stop;
        end else if (psioc && sioc && !psda && sda) begin
          check_output("stop_bitcount", nbits, 28);
          last_stop = cyc;
        end else if (!psioc && sioc) begin
          if (nbits < 27 && (nbits % 9) != 8) begin
            cur = {cur[6:0], sda};
            if ((nbits % 9) == 7)
              check_output("decoded_byte", {24'd0, cur},
                           (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hFFFF_FFFF);
          end
          nbits++;
        end
        psioc = sioc;
        psda  = sda;
      end
    end
  end

  // One write on the fast instance; optionally pulses start_i at T+100.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input bit busy_pulse);
    int cnt;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; dev = a; regb = b; dat = c;
    @(posedge clk); #1;
    start = 1'b0; dev = 8'($urandom); regb = 8'($urandom); dat = 8'($urandom);
    cnt  = 1;
    seen = 1'b0;
    while (!seen && cnt <= 1000) begin
      @(negedge clk);
      if (cnt == 1) check_output("ready_at_T+1", ready, 1'b0);
      if (cnt == BUSY) check_output("ready_at_T+464", ready, 1'b0);
      if (done) begin
        check_output("done_cycle", cnt, BUSY + 1);
        check_output("ready_at_done", ready, 1'b1);
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (busy_pulse && cnt == 99) begin
          start = 1'b1; dev = 8'($urandom); regb = 8'($urandom); dat = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        cnt++;
      end
    end
    if (!seen) check_output("done_timeout", cnt, BUSY + 1);
  endtask

  initial begin
    int guard, base, cnt, tf, tr, tf2;
    bit seen, pv;

    // Reset held with start toggling: the bus must stay idle.
    repeat (6) begin
      @(posedge clk); #1;
      start = ~start; dev = 8'($urandom);
    end
    @(negedge clk);
    check_output("reset_ready", ready, 1'b1);
    check_output("reset_sioc", sioc, 1'b1);
    check_output("reset_oe", oe, 1'b0);
    check_output("reset_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    repeat (8) @(posedge clk);

    $display("[TB] basic write with busy pulse");
    apply_stimulus(8'h42, 8'h12, 8'h80, 1'b1);
    repeat (5) @(posedge clk);

    $display("[TB] back-to-back writes");
    @(posedge clk); #1;
    start = 1'b1; dev = 8'h42; regb = 8'hA5; dat = 8'h3C;
    base  = n_accepts;
    guard = 0;
    while (n_accepts < base + 2 && guard < 2000) begin
      @(posedge clk); #1;
      if (n_accepts == base + 1) begin dev = 8'h43; regb = 8'h0F; dat = 8'hF0; end
      guard++;
    end
    start = 1'b0;
    check_output("b2b_accepts", n_accepts - base, 2);
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 1000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      guard++;
    end
    check_output("b2b_second_done", seen, 1'b1);
    check_output("b2b_gap", last_gap, 3 * Q + 1);
    repeat (5) @(posedge clk);

    $display("[TB] reset during byte 2 bit 3");
    @(posedge clk); #1;
    start = 1'b1; dev = 8'h42; regb = 8'h5A; dat = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (209) @(posedge clk);
    #2;
    check_output("pre_reset_oe", oe, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_sioc", sioc, 1'b1);
    check_output("midrst_siod", siod, 1'b1);
    check_output("midrst_oe", oe, 1'b0);
    check_output("midrst_ready", ready, 1'b1);
    check_output("midrst_done", done, 1'b0);
    repeat (3) begin @(posedge clk); #1; start = ~start; end
    rst_n = 1'b1; start = 1'b0;
    repeat (4) @(posedge clk);
    apply_stimulus(8'h42, 8'h3A, 8'h04, 1'b0);

    $display("[TB] randomized writes");
    repeat (5) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      apply_stimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    repeat (5) @(posedge clk);

    $display("[TB] default timing instance");
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; dev_b = 8'h00;
    cnt = 0; tf = -1; tr = -1; tf2 = -1; pv = 1'b1; seen = 1'b0;
    while (!seen && cnt < 31000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check_output("slow_ready_at_T+1", ready_b, 1'b0);
      if (pv && !sioc_b) begin
        if (tf < 0) tf = cnt;
        else if (tr >= 0 && tf2 < 0) tf2 = cnt;
      end
      if (!pv && sioc_b && tf >= 0 && tr < 0) tr = cnt;
      pv = sioc_b;
      if (done_b) seen = 1'b1;
    end
    check_output("slow_done_cycle", cnt, 29001);
    check_output("slow_sioc_low", tr - tf, 500);
    check_output("slow_sioc_high", tf2 - tr, 500);
    repeat (3) @(posedge clk);

    check_output("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

Single-clock SCCB (OV7670-style, I2C-compatible) 3-phase write master that programs camera registers at boot. It generates its own serial-bus timing from the system clock with an internal quarter-bit tick counter; it does not use a divided clock as a clock. Upstream it is driven by the register-init sequencer through a start/ready/done handshake. Downstream it drives the camera's SIOC/SIOD pins through an open-drain pad wrapper.

## Interface
- QUARTER_CYCLES, 250: system clocks per quarter SIOC period; 250 gives 100 kHz SIOC at 100 MHz; legal range ≥2.
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request a write; accepted only when ready_o=1.
- dev_addr_i  input  8  SCCB ID byte including the write bit (e.g. 0x42); latched on accept.
- reg_addr_i  input  8  sub-address byte; latched on accept.
- data_i  input  8  write data byte; latched on accept.
- ready_o  output  1  idle, can accept start_i.
- done_o  output  1  one-cycle pulse at transaction end.
- sioc_o  output  1  SIOC level.
- siod_o  output  1  SIOD value when driven.
- siod_oe_o  output  1  1 = drive SIOD, 0 = release (pull-up).

## Operation
- Reset (async, immediate): ready_o=1, done_o=0, sioc_o=1, siod_o=1, siod_oe_o=0, state IDLE, counters 0.
- Reset mid-transaction aborts immediately to the reset values. No STOP is generated.
- Accept: in IDLE, if start_i=1 and ready_o=1, latch the three bytes, clear the tick counter, and enter START. start_i is ignored while ready_o=0.
- Quarter tick: counter 0..QUARTER_CYCLES-1. The quarter index (q0..q3) advances when the counter wraps.
- States: IDLE → START → BYTE (3 bytes × 9 bits) → STOP → IDLE. Every non-idle phase lasts exactly 4 quarters.
- START: siod_oe_o=1. q0–q1: SIOC=1, SIOD=1. q2–q3: SIOC=1, SIOD=0.
- BYTE bit 0–7 (MSB first):
  - q0: SIOC=0; SIOD takes the new bit at q0 entry.
  - q1: SIOC=0.
  - q2–q3: SIOC=1, SIOD held.
- Bit 8 (don't-care/ACK): same SIOC pattern, siod_oe_o=0 for all 4 quarters. The value SIOD reads back is never sampled, so a missing ACK is not an error.
- Byte order: dev_addr, reg_addr, data.
- STOP: siod_oe_o=1. q0–q1: SIOC=0, SIOD=0. q2: SIOC=1, SIOD=0. q3: SIOC=1, SIOD=1.
- Return to IDLE: siod_oe_o=0, sioc_o=1, siod_o=1, ready_o=1, done_o=1 for exactly one cycle.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Accept at cycle T (start_i=1, ready_o=1): ready_o=0 from T+1; the START q0 counter begins at T+1.
- Total busy length: (4 + 108 + 4) quarters = 116·QUARTER_CYCLES cycles.
- done_o=1 and ready_o=1 at cycle T+1+116·QUARTER_CYCLES.
- A new start_i may be accepted in that same done cycle; its transaction starts the following cycle, so back-to-back writes have zero idle gap.
- SIOC high/low time is exactly 2·QUARTER_CYCLES cycles each; no jitter or stretch.
- SIOD changes only at the start of q0 while SIOC=0. The exceptions are START q2 and STOP q3, which change SIOD while SIOC=1 to form the start and stop conditions.
- Latched bytes are immune to input changes after acceptance.

## Test plan
- Reset: hold rst_ni=0, toggle start_i → ready_o=1, sioc_o=1, siod_oe_o=0, done_o=0 throughout. Release → no activity until start_i.
- Basic write, QUARTER_CYCLES=4, bytes 0x42/0x12/0x80, start at T:
  - bus decoder recovers 0x42, 0x12, 0x80 with valid START and STOP;
  - siod_oe_o=0 during each 9th bit;
  - done_o single pulse at T+465; ready_o low T+1..T+464.
- Busy ignore: pulse start_i with different bytes at T+100 → the transaction is still 0x42/0x12/0x80 and exactly one done_o.
- Back-to-back: start_i held high continuously → second transaction begins the cycle after done_o; the decoder sees two complete transactions with no gap beyond STOP→START.
- Mid-op reset: assert rst_ni=0 during byte 2 bit 3 → same-cycle async return to idle values. After release, a new write (0x42/0x3A/0x04) completes correctly.
- Default timing, QUARTER_CYCLES=250: measure SIOC → 500-cycle high and 500-cycle low; done_o at T+29001.
